// File: rtl/prog_seq_if.sv
// ============================================================================
//  Module      : prog_seq_if
//  Description : Handshake and fetch-control bundle of the program sequencer.
//                master modport = sequencer side, slave modport = bench/fetch
//                side.
//  Signals     : Start (bench -> seq), Halt_in (fetch -> seq),
//                Core_init, Load_pc, Start_addr[PC_W], ProgState[2], Busy,
//                Ack, Timeout, Cycle_count[WDOG_W] (seq -> bench/fetch)
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface prog_seq_if #(
  parameter int PC_W   = 10,
  parameter int WDOG_W = 16
) ();
  logic              Start;
  logic              Halt_in;
  logic              Core_init;
  logic              Load_pc;
  logic [PC_W-1:0]   Start_addr;
  logic [1:0]        ProgState;
  logic              Busy;
  logic              Ack;
  logic              Timeout;
  logic [WDOG_W-1:0] Cycle_count;

  modport master (
    input  Start, Halt_in,
    output Core_init, Load_pc, Start_addr, ProgState, Busy, Ack, Timeout,
           Cycle_count
  );

  modport slave (
    output Start, Halt_in,
    input  Core_init, Load_pc, Start_addr, ProgState, Busy, Ack, Timeout,
           Cycle_count
  );
endinterface

`default_nettype wire

// File: rtl/prog_sequencer.sv
// ============================================================================
//  Module      : prog_sequencer
//  Description : Run controller for the fetch unit. Steps through up to three
//                stored programs: holds fetch in init, pulses a PC load with
//                the program base address, releases the core, waits for Halt
//                (or a watchdog abort) and reports Ack back to the bench.
//  Ports       : CLK     - clock, all state changes on posedge
//                Init_n  - synchronous active-low reset
//                bus     - prog_seq_if.master
//                  Start       in   bench request (high = load/hold, low = go)
//                  Halt_in     in   halt flag from fetch unit
//                  Core_init   out  1 = fetch frozen
//                  Load_pc     out  one-cycle PC load strobe
//                  Start_addr  out  base address of current program
//                  ProgState   out  current program index 0..2
//                  Busy        out  1 while the program runs
//                  Ack         out  1 when the program finished or aborted
//                  Timeout     out  1 with Ack when the watchdog forced exit
//                  Cycle_count out  run length of the last program
//  Options     : PROG_SEQ_CYCLE_CNT_EN - when defined, Cycle_count captures
//                the number of RUN cycles of the last program; otherwise it
//                is tied to zero and no register is built.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module prog_sequencer #(
  parameter int                PC_W       = 10,
  parameter logic [PC_W-1:0]   P0_BASE    = 10'd0,
  parameter logic [PC_W-1:0]   P1_BASE    = 10'd128,
  parameter logic [PC_W-1:0]   P2_BASE    = 10'd256,
  parameter int                WDOG_W     = 16,
  parameter logic [WDOG_W-1:0] WDOG_LIMIT = 16'hFFFF
) (
  input  wire logic  CLK,
  input  wire logic  Init_n,
  prog_seq_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_HOLD = 3'd2,
    S_RUN  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // Watchdog value seen on the last permitted RUN cycle.
  localparam logic [WDOG_W-1:0] c_wdog_last = WDOG_LIMIT - 1'b1;

  state_t            r_state;
  logic [1:0]        r_prog_state;
  logic              r_core_init;
  logic              r_load_pc;
  logic              r_busy;
  logic              r_ack;
  logic              r_timeout;
  logic [WDOG_W-1:0] r_wdog;
  logic [WDOG_W-1:0] w_wdog_next;
  logic [PC_W-1:0]   w_start_addr;
  logic              w_run_exit;

`ifdef PROG_SEQ_CYCLE_CNT_EN
  logic [WDOG_W-1:0] r_cycle_count;
`endif

  // Saturating increment: the watchdog never wraps back to zero in RUN.
  assign w_wdog_next = (r_wdog == {WDOG_W{1'b1}}) ? r_wdog : r_wdog + 1'b1;

  // Halt has priority over the watchdog limit; both leave RUN.
  assign w_run_exit = bus.Halt_in || (r_wdog == c_wdog_last);

  always_comb begin
    w_start_addr = P0_BASE;
    case (r_prog_state)
      2'd0:    w_start_addr = P0_BASE;
      2'd1:    w_start_addr = P1_BASE;
      default: w_start_addr = P2_BASE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!Init_n) begin
      r_state      <= S_IDLE;
      r_prog_state <= 2'd0;
      r_core_init  <= 1'b1;
      r_load_pc    <= 1'b0;
      r_busy       <= 1'b0;
      r_ack        <= 1'b0;
      r_timeout    <= 1'b0;
      r_wdog       <= '0;
`ifdef PROG_SEQ_CYCLE_CNT_EN
      r_cycle_count <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.Start) begin
            r_state   <= S_LOAD;
            r_load_pc <= 1'b1;
          end
        end

        S_LOAD: begin
          r_state   <= S_HOLD;
          r_load_pc <= 1'b0;
        end

        S_HOLD: begin
          if (!bus.Start) begin
            r_state     <= S_RUN;
            r_core_init <= 1'b0;
            r_busy      <= 1'b1;
            r_wdog      <= '0;
          end
        end

        S_RUN: begin
          r_wdog <= w_wdog_next;
          if (w_run_exit) begin
            r_state      <= S_DONE;
            r_core_init  <= 1'b1;
            r_busy       <= 1'b0;
            r_ack        <= 1'b1;
            r_timeout    <= !bus.Halt_in;
            r_prog_state <= (r_prog_state == 2'd2) ? 2'd0 : r_prog_state + 2'd1;
`ifdef PROG_SEQ_CYCLE_CNT_EN
            // Includes the exit cycle itself, i.e. total cycles spent in RUN.
            r_cycle_count <= w_wdog_next;
`endif
          end
        end

        S_DONE: begin
          if (bus.Start) begin
            r_state   <= S_LOAD;
            r_load_pc <= 1'b1;
            r_ack     <= 1'b0;
            r_timeout <= 1'b0;
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_core_init <= 1'b1;
          r_load_pc   <= 1'b0;
          r_busy      <= 1'b0;
          r_ack       <= 1'b0;
          r_timeout   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Core_init  = r_core_init;
  assign bus.Load_pc    = r_load_pc;
  assign bus.Start_addr = w_start_addr;
  assign bus.ProgState  = r_prog_state;
  assign bus.Busy       = r_busy;
  assign bus.Ack        = r_ack;
  assign bus.Timeout    = r_timeout;

`ifdef PROG_SEQ_CYCLE_CNT_EN
  assign bus.Cycle_count = r_cycle_count;
`else
  assign bus.Cycle_count = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_prog_sequencer.sv
// ============================================================================
//  Module      : tb_prog_sequencer
//  Description : Self-checking bench for prog_sequencer. Two instances share
//                one stimulus: u_dut_a (watchdog limit 40) for normal runs and
//                u_dut_b (watchdog limit 8) for the watchdog corner cases.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_prog_sequencer;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic Init_n;
  logic start;
  logic halt;

  int errors = 0;
  int checks = 0;

`ifdef PROG_SEQ_CYCLE_CNT_EN
  localparam bit c_cc_en = 1'b1;
`else
  localparam bit c_cc_en = 1'b0;
`endif

  prog_seq_if #(.PC_W(10), .WDOG_W(16)) ifa ();
  prog_seq_if #(.PC_W(10), .WDOG_W(16)) ifb ();

  assign ifa.Start   = start;
  assign ifa.Halt_in = halt;
  assign ifb.Start   = start;
  assign ifb.Halt_in = halt;

  prog_sequencer #(.WDOG_LIMIT(16'd40)) u_dut_a (.CLK(CLK), .Init_n(Init_n), .bus(ifa));
  prog_sequencer #(.WDOG_LIMIT(16'd8))  u_dut_b (.CLK(CLK), .Init_n(Init_n), .bus(ifb));

  // Packed view: {Core_init, Load_pc, Start_addr[9:0], ProgState[1:0], Busy, Ack, Timeout}
  wire [16:0] obs_a = {ifa.Core_init, ifa.Load_pc, ifa.Start_addr, ifa.ProgState,
                       ifa.Busy, ifa.Ack, ifa.Timeout};
  wire [16:0] obs_b = {ifb.Core_init, ifb.Load_pc, ifb.Start_addr, ifb.ProgState,
                       ifb.Busy, ifb.Ack, ifb.Timeout};

  function automatic logic [16:0] pk(bit ci, bit lp, logic [9:0] addr, logic [1:0] ps,
                                     bit busy, bit ack, bit to);
    return {ci, lp, addr, ps, busy, ack, to};
  endfunction

  function automatic logic [16:0] obs(int d);
    return (d == 0) ? obs_a : obs_b;
  endfunction

  function automatic logic [15:0] ccnt(int d);
    return (d == 0) ? ifa.Cycle_count : ifb.Cycle_count;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // One program: Start high 3 cycles, then low; Halt pulsed on RUN cycle
  // number halt_at (0 = never). Reports Load_pc pulses, RUN cycles and the
  // Start_addr seen while loading.
  task automatic do_run(input int d, input int halt_at, output int lp_cnt,
                        output int busy_cnt, output logic [9:0] addr);
    logic [16:0] v;
    lp_cnt   = 0;
    busy_cnt = 0;
    start = 1'b1;
    step();
    v = obs(d);
    lp_cnt += int'(v[15]);
    addr = v[14:5];
    repeat (2) begin
      step();
      v = obs(d);
      lp_cnt += int'(v[15]);
    end
    start = 1'b0;
    step();
    v = obs(d);
    lp_cnt += int'(v[15]);
    for (int k = 0; k < 100 && v[2]; k++) begin
      busy_cnt++;
      halt = (busy_cnt == halt_at);
      step();
      halt = 1'b0;
      v = obs(d);
    end
  endtask

  typedef struct {
    bit          rstn;
    bit          st;
    bit          hl;
    logic [16:0] exp;
  } vec_t;

  vec_t tbl [17];

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int          lp;
    int          bc;
    logic [9:0]  ad;

    //           rstn  st    hl    expected {ci,lp,addr,ps,busy,ack,to}
    tbl[0]  = '{1'b0, 1'b0, 1'b0, pk(1, 0, 10'd0,   2'd0, 0, 0, 0)}; // reset
    tbl[1]  = '{1'b1, 1'b0, 1'b1, pk(1, 0, 10'd0,   2'd0, 0, 0, 0)}; // halt ignored in IDLE
    tbl[2]  = '{1'b1, 1'b1, 1'b0, pk(1, 1, 10'd0,   2'd0, 0, 0, 0)}; // LOAD
    tbl[3]  = '{1'b1, 1'b1, 1'b0, pk(1, 0, 10'd0,   2'd0, 0, 0, 0)}; // HOLD
    tbl[4]  = '{1'b1, 1'b1, 1'b0, pk(1, 0, 10'd0,   2'd0, 0, 0, 0)}; // HOLD
    tbl[5]  = '{1'b1, 1'b0, 1'b0, pk(0, 0, 10'd0,   2'd0, 1, 0, 0)}; // RUN
    tbl[6]  = '{1'b1, 1'b1, 1'b0, pk(0, 0, 10'd0,   2'd0, 1, 0, 0)}; // Start ignored in RUN
    tbl[7]  = '{1'b1, 1'b0, 1'b1, pk(1, 0, 10'd128, 2'd1, 0, 1, 0)}; // halt -> DONE
    tbl[8]  = '{1'b1, 1'b0, 1'b1, pk(1, 0, 10'd128, 2'd1, 0, 1, 0)}; // stay DONE
    tbl[9]  = '{1'b1, 1'b1, 1'b0, pk(1, 1, 10'd128, 2'd1, 0, 0, 0)}; // LOAD, Ack cleared
    tbl[10] = '{1'b1, 1'b0, 1'b0, pk(1, 0, 10'd128, 2'd1, 0, 0, 0)}; // HOLD
    tbl[11] = '{1'b1, 1'b0, 1'b0, pk(0, 0, 10'd128, 2'd1, 1, 0, 0)}; // RUN
    tbl[12] = '{1'b1, 1'b1, 1'b1, pk(1, 0, 10'd256, 2'd2, 0, 1, 0)}; // DONE with Start high
    tbl[13] = '{1'b1, 1'b1, 1'b0, pk(1, 1, 10'd256, 2'd2, 0, 0, 0)}; // one Ack cycle then LOAD
    tbl[14] = '{1'b1, 1'b0, 1'b0, pk(1, 0, 10'd256, 2'd2, 0, 0, 0)}; // HOLD
    tbl[15] = '{1'b1, 1'b0, 1'b0, pk(0, 0, 10'd256, 2'd2, 1, 0, 0)}; // RUN
    tbl[16] = '{1'b0, 1'b0, 1'b0, pk(1, 0, 10'd0,   2'd0, 0, 0, 0)}; // reset mid-RUN

    Init_n = 1'b0;
    start  = 1'b0;
    halt   = 1'b0;

    for (int i = 0; i < 17; i++) begin
      Init_n = tbl[i].rstn;
      start  = tbl[i].st;
      halt   = tbl[i].hl;
      step();
      check($sformatf("vec%0d_a", i), 32'(obs_a), 32'(tbl[i].exp));
      check($sformatf("vec%0d_b", i), 32'(obs_b), 32'(tbl[i].exp));
    end
    check("reset_cc_a", 32'(ifa.Cycle_count), 32'd0);
    Init_n = 1'b1;
    start  = 1'b0;
    halt   = 1'b0;

    // Three full runs on instance A: base addresses and ProgState wrap.
    Init_n = 1'b0;
    step();
    Init_n = 1'b1;
    do_run(0, 20, lp, bc, ad);
    check("run1_load_pulses", 32'(lp), 32'd1);
    check("run1_addr",        32'(ad), 32'd0);
    check("run1_busy_cycles", 32'(bc), 32'd20);
    check("run1_outputs",     32'(obs_a), 32'(pk(1, 0, 10'd128, 2'd1, 0, 1, 0)));
    check("run1_cycle_count", 32'(ccnt(0)), c_cc_en ? 32'd20 : 32'd0);
    step();
    check("run1_ack_held",    32'(obs_a), 32'(pk(1, 0, 10'd128, 2'd1, 0, 1, 0)));

    do_run(0, 5, lp, bc, ad);
    check("run2_addr",        32'(ad), 32'd128);
    check("run2_busy_cycles", 32'(bc), 32'd5);
    check("run2_outputs",     32'(obs_a), 32'(pk(1, 0, 10'd256, 2'd2, 0, 1, 0)));
    check("run2_cycle_count", 32'(ccnt(0)), c_cc_en ? 32'd5 : 32'd0);

    do_run(0, 5, lp, bc, ad);
    check("run3_addr",        32'(ad), 32'd256);
    check("run3_wrap",        32'(obs_a), 32'(pk(1, 0, 10'd0, 2'd0, 0, 1, 0)));

    // Watchdog corner cases on instance B (limit 8).
    Init_n = 1'b0;
    step();
    Init_n = 1'b1;
    do_run(1, 0, lp, bc, ad);
    check("wdog_load_pulses", 32'(lp), 32'd1);
    check("wdog_busy_cycles", 32'(bc), 32'd8);
    check("wdog_outputs",     32'(obs_b), 32'(pk(1, 0, 10'd128, 2'd1, 0, 1, 1)));
    check("wdog_cycle_count", 32'(ccnt(1)), c_cc_en ? 32'd8 : 32'd0);
    step();
    check("wdog_timeout_held", 32'(obs_b), 32'(pk(1, 0, 10'd128, 2'd1, 0, 1, 1)));

    do_run(1, 8, lp, bc, ad);
    check("halt_wins_busy",   32'(bc), 32'd8);
    check("halt_wins_outputs", 32'(obs_b), 32'(pk(1, 0, 10'd256, 2'd2, 0, 1, 0)));
    check("halt_wins_cc",     32'(ccnt(1)), c_cc_en ? 32'd8 : 32'd0);

    do_run(1, 3, lp, bc, ad);
    check("short_run_busy",   32'(bc), 32'd3);
    check("short_run_cc",     32'(ccnt(1)), c_cc_en ? 32'd3 : 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
